memref_rd_server: RTL and testbench

- Memory-side responder for a kernel's read-only memref port: addr, rd_en, rd_data with 1-cycle read latency.
- Loads a full frame from an upstream valid/ready stream into internal storage.
- Pulses the kernel's tstart, then serves the kernel's reads until the kernel signals completion.
- Sits between the DMA/stream front end and a generated kernel, e.g. a 64x64 8-bit image feeding a histogram kernel.

---
 rtl/memref_rd_server.sv | 81 ++++++++
 tb/tb_memref_rd_server.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/memref_rd_server.sv
// memref_rd_server: loads a frame from a valid/ready stream, pulses tstart, then serves 1-cycle-latency kernel reads until kdone.
// Optional macro MEMREF_RD_SERVER_RD_COUNT_EN enables the in-range read counter on rd_count.
module memref_rd_server #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int DEPTH = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic s_ready,
  output logic tstart,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic rd_en,
  output logic [DATA_W-1:0] rd_data,
  input  logic kdone,
  output logic busy,
  output logic err,
  output logic [31:0] rd_count
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  typedef enum logic [1:0] {LOAD, START, SERVE} state_t;
  state_t state;
  logic [ADDR_W:0] wp;
  logic [DATA_W-1:0] mem [DEPTH];
  logic accept, rd_ok;
  assign accept = s_valid && s_ready;
  assign rd_ok = rd_en && state == SERVE && {1'b0, rd_addr} <= LAST;
  always_ff @(posedge clk)
    if (accept) mem[wp[IDX_W-1:0]] <= s_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= LOAD;
      wp <= '0;
      s_ready <= 1'b0;
      tstart <= 1'b0;
      busy <= 1'b0;
    end else begin
      tstart <= 1'b0;
      case (state)
        LOAD: begin
          s_ready <= 1'b1;
          if (accept) begin
            wp <= wp == LAST ? '0 : wp + 1'b1;
            if (wp == LAST) begin
              s_ready <= 1'b0;
              tstart <= 1'b1;
              busy <= 1'b1;
              state <= START;
            end
          end
        end
        START: state <= SERVE;
        SERVE: if (kdone) begin
          state <= LOAD;
          busy <= 1'b0;
          s_ready <= 1'b1;
        end
        default: state <= LOAD;
      endcase
    end
  // rejected reads return 0 so the kernel never sees stale or partially loaded data
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_data <= '0;
      err <= 1'b0;
    end else begin
      if (rd_en) rd_data <= rd_ok ? mem[rd_addr[IDX_W-1:0]] : '0;
      if ((rd_en && !rd_ok) || (kdone && state != SERVE)) err <= 1'b1;
    end
`ifdef MEMREF_RD_SERVER_RD_COUNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_count <= '0;
    else if (state == START) rd_count <= '0;
    else if (rd_ok && rd_count != '1) rd_count <= rd_count + 1'b1;
`else
  assign rd_count = '0;
`endif
endmodule

// File: tb/tb_memref_rd_server.sv
// tb_memref_rd_server: two instances (DEPTH 4096 and 3000) driven with directed and random traffic against a frame-level model.
module tb_memref_rd_server;
  localparam int DEP [2] = '{4096, 3000};
  logic clk = 1'b0;
  logic rst;
  logic s_valid [2];
  logic [7:0] s_data [2];
  logic s_ready [2];
  logic tstart [2];
  logic [11:0] rd_addr [2];
  logic rd_en [2];
  logic [7:0] rd_data [2];
  logic kdone [2];
  logic busy [2];
  logic err [2];
  logic [31:0] rd_count [2];
  int checks = 0;
  int failures = 0;
  logic [7:0] mem_m [2][4096];
  logic [7:0] exp_rd [2];
  bit err_m [2];
  int rdcnt_m [2];
  bit serving [2];

  always #5 clk = ~clk;

  memref_rd_server #(.ADDR_W(12), .DATA_W(8), .DEPTH(4096)) u0 (
    .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_data(s_data[0]), .s_ready(s_ready[0]),
    .tstart(tstart[0]), .rd_addr(rd_addr[0]), .rd_en(rd_en[0]), .rd_data(rd_data[0]),
    .kdone(kdone[0]), .busy(busy[0]), .err(err[0]), .rd_count(rd_count[0]));

  memref_rd_server #(.ADDR_W(12), .DATA_W(8), .DEPTH(3000)) u1 (
    .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_data(s_data[1]), .s_ready(s_ready[1]),
    .tstart(tstart[1]), .rd_addr(rd_addr[1]), .rd_en(rd_en[1]), .rd_data(rd_data[1]),
    .kdone(kdone[1]), .busy(busy[1]), .err(err[1]), .rd_count(rd_count[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int d);
`ifdef MEMREF_RD_SERVER_RD_COUNT_EN
    return rdcnt_m[d];
`else
    return 0;
`endif
  endfunction

  function automatic logic [7:0] val(input int mode, input int i);
    return mode == 0 ? i[7:0] : mode == 1 ? 8'hA5 : 8'($urandom);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = 1'b0; s_data[d] = '0; rd_en[d] = 1'b0; rd_addr[d] = '0; kdone[d] = 1'b0;
      exp_rd[d] = '0; err_m[d] = 1'b0; rdcnt_m[d] = 0; serving[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_s_ready", s_ready[d], 0);
      chk("rst_tstart", tstart[d], 0);
      chk("rst_rd_data", rd_data[d], 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_err", err[d], 0);
      chk("rst_rd_count", rd_count[d], 0);
    end
    repeat (2) @(negedge clk);
    chk("rst_hold_s_ready", s_ready[0], 0);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("post_rst_s_ready", s_ready[d], 1);
  endtask

  task automatic load(input int d, input int mode, input bit gaps, input int n);
    int acc = 0;
    int cyc = 0;
    int early = 0;
    while (acc < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (tstart[d]) early++;
      s_valid[d] = gaps ? ($urandom_range(3) != 0) : 1'b1;
      s_data[d] = val(mode, acc);
      if (s_valid[d] && s_ready[d]) begin
        mem_m[d][acc] = s_data[d];
        acc++;
      end
    end
    if (n < DEP[d]) return;
    @(negedge clk);
    s_valid[d] = 1'b1;
    s_data[d] = 8'h3C;
    chk("accepts", acc, DEP[d]);
    chk("no_early_tstart", early, 0);
    if (!gaps) chk("full_rate_cycles", cyc, DEP[d]);
    chk("tstart_pulse", tstart[d], 1);
    chk("busy_start", busy[d], 1);
    chk("s_ready_drop", s_ready[d], 0);
    @(negedge clk);
    s_valid[d] = 1'b0;
    chk("tstart_once", tstart[d], 0);
    chk("busy_serve", busy[d], 1);
    serving[d] = 1'b1;
    rdcnt_m[d] = 0;
  endtask

  task automatic cyc(input int d, input bit en, input int a, input bit kd, input string tag);
    @(negedge clk);
    chk(tag, rd_data[d], exp_rd[d]);
    chk("busy", busy[d], serving[d]);
    chk("err", err[d], err_m[d]);
    chk("rd_count", rd_count[d], exp_cnt(d));
    rd_en[d] = en;
    rd_addr[d] = a[11:0];
    kdone[d] = kd;
    if (en) begin
      if (serving[d] && a < DEP[d]) begin
        exp_rd[d] = mem_m[d][a];
        rdcnt_m[d]++;
      end else begin
        exp_rd[d] = '0;
        err_m[d] = 1'b1;
      end
    end
    if (kd) begin
      if (!serving[d]) err_m[d] = 1'b1;
      serving[d] = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0;
    @(negedge clk);
    do_reset();
    load(0, 0, 0, 4096);
    cyc(0, 1, 0, 0, "rd_a0");
    cyc(0, 1, 1, 0, "rd_a1");
    cyc(0, 1, 4095, 0, "rd_a4095");
    cyc(0, 1, 300, 0, "rd_a300");
    repeat (3) cyc(0, 0, 0, 0, "rd_hold");
    chk("rd_hold_2c", rd_data[0], 8'h2C);
    repeat (300) cyc(0, 1'($urandom_range(1)), $urandom_range(4095), 0, "rd_rand");
    cyc(0, 1, 5, 1, "rd_kdone");
    cyc(0, 0, 0, 0, "rd_after_kdone");
    chk("rd_kdone_05", rd_data[0], 8'h05);
    chk("s_ready_reload", s_ready[0], 1);
    cyc(0, 1, 7, 0, "rd_in_load");
    cyc(0, 0, 0, 0, "rd_in_load_zero");
    chk("err_load", err[0], 1);
    load(0, 1, 1, 4096);
    repeat (200) cyc(0, 1'($urandom_range(1)), $urandom_range(4095), 0, "rd_a5");
    cyc(0, 0, 0, 1, "kd2");
    cyc(0, 0, 0, 0, "post_kd2");
    chk("err_sticky", err[0], 1);
    load(1, 2, 0, 3000);
    for (int a = 0; a < 3000; a++) cyc(1, 1, a, 0, "rd1_seq");
    cyc(1, 0, 0, 0, "rd1_tail");
    chk("err1_clean", err[1], 0);
    cyc(1, 1, 3000, 0, "rd1_oor");
    cyc(1, 1, 4095, 0, "rd1_oor_top");
    cyc(1, 1, 2999, 0, "rd1_last");
    cyc(1, 0, 0, 1, "rd1_kd");
    cyc(1, 0, 0, 0, "rd1_post");
    chk("err1_oor", err[1], 1);
    load(0, 2, 0, 100);
    do_reset();
    cyc(1, 0, 0, 1, "kd_in_load");
    cyc(1, 0, 0, 0, "kd_in_load_chk");
    chk("kd_in_load_s_ready", s_ready[1], 1);
    load(0, 2, 1, 4096);
    for (int a = 0; a < 4096; a++) cyc(0, 1, a, 0, "rd_reload");
    cyc(0, 0, 0, 0, "rd_reload_tail");
    chk("rd_count_full", rd_count[0], exp_cnt(0));
    chk("err_after_reset", err[0], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
